// File: rtl/ul_bfp_pkg.sv
// Shared defaults, FSM state type and helpers for the uplink BFP compressor.
package ul_bfp_pkg;
  localparam int IW_DEF     = 16;
  localparam int MW_DEF     = 9;
  localparam int NSC_DEF    = 12;
  localparam int EW_DEF     = 4;
  localparam int META_W_DEF = 24;
  localparam int MW_MIN     = 2;

  typedef enum logic {IDLE, COLLECT} state_t;

  // Position of the highest set bit plus one; 0 for an all-zero word.
  function automatic int bitlen(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if (v[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [3:0] clamp_mw(input logic [3:0] mw, input int mw_max);
    logic [3:0] r;
    if (int'(mw) < MW_MIN)
      r = 4'(MW_MIN);
    else if (int'(mw) > mw_max)
      r = 4'(mw_max);
    else
      r = mw;
    return r;
  endfunction
endpackage

// File: rtl/ul_bfp_quant.sv
// One IQ component: round-half-up shift by the block exponent, then saturate to mw bits.
// Two register stages, free-running (no flow control); sat flag only with UL_BFP_SAT_CNT_EN.
module ul_bfp_quant
  import ul_bfp_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int MW = MW_DEF,
  parameter int EW = EW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] x,
  input  logic [EW-1:0]        shift,
  input  logic [3:0]           mw,
  output logic [MW-1:0]        q
`ifdef UL_BFP_SAT_CNT_EN
  , output logic               sat
`endif
);
  localparam logic signed [IW:0] ONE_W = 1;
  localparam logic [MW-1:0]      ONE_M = 1;

  logic signed [IW:0] rnd, sh_val, s1_val, hi_w, lo_w;
  logic [3:0]         s1_mw, s1_sh;
  logic [MW-1:0]      hi_m, lo_m, q_nx;
  logic               over, under;

  // One guard bit keeps x + rounding constant exact before the arithmetic shift.
  always_comb begin
    rnd = '0;
    if (shift != '0)
      rnd = ONE_W <<< (shift - 1'b1);
    sh_val = ($signed({x[IW-1], x}) + rnd) >>> shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_val <= '0;
      s1_mw  <= '0;
    end else begin
      s1_val <= sh_val;
      s1_mw  <= mw;
    end
  end

  always_comb begin
    s1_sh = s1_mw - 4'd1;
    hi_w  = (ONE_W <<< s1_sh) - ONE_W;
    lo_w  = -(ONE_W <<< s1_sh);
    hi_m  = (ONE_M << s1_sh) - ONE_M;
    lo_m  = -(ONE_M << s1_sh);
    over  = (s1_val > hi_w);
    under = (s1_val < lo_w);
    q_nx  = over ? hi_m : (under ? lo_m : s1_val[MW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
`ifdef UL_BFP_SAT_CNT_EN
      sat <= 1'b0;
`endif
    end else begin
      q <= q_nx;
`ifdef UL_BFP_SAT_CNT_EN
      sat <= over | under;
`endif
    end
  end
endmodule

// File: rtl/ul_bfp_compress_gen.sv
// Uplink BFP compressor: one shared exponent per NSC-sample block, LAT = NSC+4, no backpressure.
// Ping-pong banks accept back-to-back blocks; UL_BFP_SAT_CNT_EN builds the o_sat_cnt counter.
module ul_bfp_compress_gen
  import ul_bfp_pkg::*;
#(
  parameter int IW     = IW_DEF,
  parameter int MW     = MW_DEF,
  parameter int NSC    = NSC_DEF,
  parameter int EW     = EW_DEF,
  parameter int META_W = META_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [2*IW-1:0]   i_din,
  input  logic [3:0]        i_mw,
  input  logic [META_W-1:0] i_meta,
  output logic              o_vld,
  output logic              o_sop,
  output logic              o_eop,
  output logic [2*MW-1:0]   o_dout,
  output logic [EW-1:0]     o_exp,
  output logic [META_W-1:0] o_meta,
  output logic              o_err,
  output logic [15:0]       o_sat_cnt
);
  localparam int CW = $clog2(NSC);

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, wr_idx, rd_cnt;
  logic              wr_en, blk_done, blk_drop, last_ok;
  logic              wr_bank, done_q, done_bank, rd_act, rd_bank;
  logic [IW-1:0]     mag_i, mag_q, or_acc, or_nx, or_done;
  logic [3:0]        mw_wr, mw_cur, mw_done, mw_blk, mw0;
  logic [META_W-1:0] meta_wr, meta_cur, meta_done, meta_blk;
  logic [EW-1:0]     exp_blk, exp_nx, exp0;
  int                b_len;
  logic [2*IW-1:0]   mem [2][NSC];
  logic [2*IW-1:0]   dat0;
  logic              v0, sop0, eop0, v1, sop1, eop1, v2, sop2, eop2;
  logic [MW-1:0]     q_i, q_q;
`ifdef UL_BFP_SAT_CNT_EN
  logic              sat_i, sat_q;
  logic [16:0]       sat_sum;
`endif

  assign mag_i    = i_din[2*IW-1:IW] ^ {IW{i_din[2*IW-1]}};
  assign mag_q    = i_din[IW-1:0]    ^ {IW{i_din[IW-1]}};
  assign wr_idx   = (state == IDLE || i_sop) ? '0 : cnt;
  assign last_ok  = (wr_idx == CW'(NSC - 1));
  assign or_nx    = ((wr_idx == '0) ? '0 : or_acc) | mag_i | mag_q;
  assign mw_cur   = (wr_idx == '0) ? clamp_mw(i_mw, MW) : mw_wr;
  assign meta_cur = (wr_idx == '0) ? i_meta : meta_wr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A new i_sop inside a block aborts it and restarts at index 0 in the same bank.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    blk_done = 1'b0;
    blk_drop = 1'b0;
    case (state)
      IDLE: begin
        if (i_vld && i_sop) begin
          wr_en = 1'b1;
          if (i_eop) begin
            if (last_ok) blk_done = 1'b1;
            else         blk_drop = 1'b1;
          end else if (last_ok) blk_drop = 1'b1;
          else                  state_nx = COLLECT;
        end
      end
      COLLECT: begin
        if (!i_vld) begin
          blk_drop = 1'b1;
          state_nx = IDLE;
        end else begin
          wr_en = 1'b1;
          if (i_sop) blk_drop = 1'b1;
          if (i_eop) begin
            state_nx = IDLE;
            if (last_ok) blk_done = 1'b1;
            else         blk_drop = 1'b1;
          end else if (last_ok) begin
            state_nx = IDLE;
            blk_drop = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_idx] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      or_acc    <= '0;
      mw_wr     <= '0;
      meta_wr   <= '0;
      wr_bank   <= 1'b0;
      done_q    <= 1'b0;
      or_done   <= '0;
      mw_done   <= '0;
      meta_done <= '0;
      done_bank <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_err  <= blk_drop;
      done_q <= blk_done;
      if (wr_en) begin
        cnt     <= wr_idx + 1'b1;
        or_acc  <= or_nx;
        mw_wr   <= mw_cur;
        meta_wr <= meta_cur;
      end
      if (blk_done) begin
        or_done   <= or_nx;
        mw_done   <= mw_cur;
        meta_done <= meta_cur;
        done_bank <= wr_bank;
        wr_bank   <= ~wr_bank;
      end
    end
  end

  always_comb begin
    b_len  = bitlen(32'(or_done));
    exp_nx = (b_len + 1 > int'(mw_done)) ? EW'(b_len + 1 - int'(mw_done)) : '0;
  end

  // Block parameters change at most once per NSC cycles, so they stay stable until the block's o_sop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_act   <= 1'b0;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      exp_blk  <= '0;
      mw_blk   <= '0;
      meta_blk <= '0;
    end else if (done_q) begin
      rd_act   <= 1'b1;
      rd_cnt   <= '0;
      rd_bank  <= done_bank;
      exp_blk  <= exp_nx;
      mw_blk   <= mw_done;
      meta_blk <= meta_done;
    end else if (rd_act) begin
      if (rd_cnt == CW'(NSC - 1)) rd_act <= 1'b0;
      else                        rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    dat0 <= mem[rd_bank][rd_cnt];
  end

  // exp/mw ride with each sample: the next block's exp_blk lands while this block's tail is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      {v0, sop0, eop0, v1, sop1, eop1, v2, sop2, eop2} <= '0;
      exp0 <= '0;
      mw0  <= '0;
    end else begin
      v0   <= rd_act;
      sop0 <= rd_act && (rd_cnt == '0);
      eop0 <= rd_act && (rd_cnt == CW'(NSC - 1));
      exp0 <= exp_blk;
      mw0  <= mw_blk;
      {v1, sop1, eop1} <= {v0, sop0, eop0};
      {v2, sop2, eop2} <= {v1, sop1, eop1};
    end
  end

  ul_bfp_quant #(.IW(IW), .MW(MW), .EW(EW)) u_quant_i (
    .clk   (clk),
    .rst   (rst),
    .x     (dat0[2*IW-1:IW]),
    .shift (exp0),
    .mw    (mw0),
    .q     (q_i)
`ifdef UL_BFP_SAT_CNT_EN
    , .sat (sat_i)
`endif
  );

  ul_bfp_quant #(.IW(IW), .MW(MW), .EW(EW)) u_quant_q (
    .clk   (clk),
    .rst   (rst),
    .x     (dat0[IW-1:0]),
    .shift (exp0),
    .mw    (mw0),
    .q     (q_q)
`ifdef UL_BFP_SAT_CNT_EN
    , .sat (sat_q)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_sop  <= 1'b0;
      o_eop  <= 1'b0;
      o_dout <= '0;
      o_exp  <= '0;
      o_meta <= '0;
    end else begin
      o_vld  <= v2;
      o_sop  <= sop2;
      o_eop  <= eop2;
      o_dout <= v2 ? {q_i, q_q} : '0;
      if (sop2) begin
        o_exp  <= exp_blk;
        o_meta <= meta_blk;
      end
    end
  end

`ifdef UL_BFP_SAT_CNT_EN
  assign sat_sum = {1'b0, o_sat_cnt} + 17'(sat_i) + 17'(sat_q);

  always_ff @(posedge clk) begin
    if (rst)     o_sat_cnt <= '0;
    else if (v2) o_sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end
`else
  assign o_sat_cnt = '0;
`endif
endmodule

// File: tb/tb_ul_bfp_compress_gen.sv
// Directed bench for ul_bfp_compress_gen with hand-computed mantissas, exponents and timing.
module tb_ul_bfp_compress_gen;
  localparam int IW = 16, MW = 9, NSC = 12, EW = 4, META_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_vld, i_sop, i_eop;
  logic [2*IW-1:0]   i_din;
  logic [3:0]        i_mw;
  logic [META_W-1:0] i_meta;
  logic              o_vld, o_sop, o_eop, o_err;
  logic [2*MW-1:0]   o_dout;
  logic [EW-1:0]     o_exp;
  logic [META_W-1:0] o_meta;
  logic [15:0]       o_sat_cnt;

  ul_bfp_compress_gen #(.IW(IW), .MW(MW), .NSC(NSC), .EW(EW), .META_W(META_W)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop), .i_din(i_din),
    .i_mw(i_mw), .i_meta(i_meta), .o_vld(o_vld), .o_sop(o_sop), .o_eop(o_eop),
    .o_dout(o_dout), .o_exp(o_exp), .o_meta(o_meta), .o_err(o_err), .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*MW-1:0]   d;
    logic              sop;
    logic              eop;
    logic [EW-1:0]     e;
    logic [META_W-1:0] m;
    int                c;
  } rec_t;

  rec_t out_q[$];
  int   cyc = 0, checks = 0, errors = 0, err_cnt = 0, err_cyc = -1;
  int   blk_i[NSC], blk_q[NSC], exp_i[NSC], exp_q[NSC];
  int   e0, e1, sat_en;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_vld) out_q.push_back('{d: o_dout, sop: o_sop, eop: o_eop, e: o_exp, m: o_meta, c: cyc});
    if (o_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2*MW-1:0] pk(input int a, input int b);
    logic [31:0] ua, ub;
    ua = a;
    ub = b;
    return {ua[MW-1:0], ub[MW-1:0]};
  endfunction

  task automatic clr();
    for (int k = 0; k < NSC; k++) begin
      blk_i[k] = 0; blk_q[k] = 0; exp_i[k] = 0; exp_q[k] = 0;
    end
  endtask

  // mw/meta carry decoy values off the first sample so sampling at i_sop is exercised.
  task automatic drive_block(input int n, input int eop_idx, input int mw, input int meta,
                             output int edge0);
    edge0 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) edge0 = cyc + 1;
      i_vld  = 1'b1;
      i_sop  = (k == 0);
      i_eop  = (k == eop_idx);
      i_din  = {16'(blk_i[k]), 16'(blk_q[k])};
      i_mw   = (k == 0) ? 4'(mw) : 4'd3;
      i_meta = (k == 0) ? 24'(meta) : ~24'(meta);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_din = '0;
    end
  endtask

  task automatic new_test();
    out_q.delete();
    err_cnt = 0;
    err_cyc = -1;
  endtask

  task automatic check_block(input string tag, input int n, input int e, input int meta,
                             input int edge0);
    rec_t r;
    for (int k = 0; k < n; k++) begin
      if (out_q.size() == 0) begin
        check($sformatf("%s samples", tag), k, n);
        break;
      end
      r = out_q.pop_front();
      check($sformatf("%s dout[%0d]", tag, k), r.d, pk(exp_i[k], exp_q[k]));
      check($sformatf("%s cycle[%0d]", tag, k), r.c, edge0 + NSC + 4 + k);
      check($sformatf("%s sop[%0d]", tag, k), r.sop, k == 0);
      check($sformatf("%s eop[%0d]", tag, k), r.eop, k == n - 1);
      check($sformatf("%s exp[%0d]", tag, k), r.e, e);
      check($sformatf("%s meta[%0d]", tag, k), r.m, meta);
    end
  endtask

  task automatic load_t2();
    clr();
    blk_i[0] = 1000; blk_i[1] = 1003; blk_i[2] = -1001; blk_i[3] = 2;
    blk_q[0] = -4;   blk_q[1] = 6;    blk_q[2] = -6;
    exp_i[0] = 250;  exp_i[1] = 251;  exp_i[2] = -250;  exp_i[3] = 1;
    exp_q[0] = -1;   exp_q[1] = 2;    exp_q[2] = -1;
  endtask

  initial begin
`ifdef UL_BFP_SAT_CNT_EN
    sat_en = 1;
`else
    sat_en = 0;
`endif
    rst = 1'b1; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    i_din = '0; i_mw = 4'd9; i_meta = '0;
    repeat (3) @(negedge clk);
    check("rst o_vld", o_vld, 0);
    check("rst o_sop_eop", {o_sop, o_eop}, 0);
    check("rst o_dout", o_dout, 0);
    check("rst o_exp", o_exp, 0);
    check("rst o_meta", o_meta, 0);
    check("rst o_err", o_err, 0);
    check("rst o_sat_cnt", o_sat_cnt, 0);
    rst = 1'b0;

    // All-zero block
    new_test(); clr();
    drive_block(NSC, NSC - 1, 9, 'hA1, e0);
    idle(22);
    check("t1 count", out_q.size(), NSC);
    check_block("t1", NSC, 0, 'hA1, e0);
    check("t1 err", err_cnt, 0);

    // Max component 1000, exp 2, rounding both signs
    new_test(); load_t2();
    drive_block(NSC, NSC - 1, 9, 'h5A5A5A, e0);
    idle(22);
    check("t2 count", out_q.size(), NSC);
    check_block("t2", NSC, 2, 'h5A5A5A, e0);
    check("t2 sat_cnt", o_sat_cnt, 0);

    // Full scale, exp 7, positive saturation only
    new_test(); clr();
    blk_i[0] = 32767;  blk_i[1] = -32768; blk_i[2] = -129;
    blk_q[0] = -32768; blk_q[1] = 100;
    exp_i[0] = 255;    exp_i[1] = -256;   exp_i[2] = -1;
    exp_q[0] = -256;   exp_q[1] = 1;
    drive_block(NSC, NSC - 1, 9, 'h00BEEF, e0);
    idle(22);
    check("t3 count", out_q.size(), NSC);
    check_block("t3", NSC, 7, 'h00BEEF, e0);
    check("t3 sat_cnt", o_sat_cnt, sat_en);

    // Back-to-back blocks: exp 0 (mw 9) then exp 11 (mw 5)
    new_test(); clr();
    blk_i[0] = 100; blk_i[1] = -50; blk_i[2] = 7;
    blk_q[0] = -100; blk_q[1] = 3;
    drive_block(NSC, NSC - 1, 9, 'h111, e0);
    clr();
    blk_i[0] = 20000; blk_i[1] = -20000; blk_i[2] = 1024; blk_i[3] = 1023; blk_i[4] = -1025;
    blk_q[0] = 30000; blk_q[1] = -32768; blk_q[2] = 32767;
    drive_block(NSC, NSC - 1, 5, 'h222, e1);
    idle(22);
    check("t4 count", out_q.size(), 2 * NSC);
    clr();
    exp_i[0] = 100; exp_i[1] = -50; exp_i[2] = 7;
    exp_q[0] = -100; exp_q[1] = 3;
    check_block("t4a", NSC, 0, 'h111, e0);
    clr();
    exp_i[0] = 10; exp_i[1] = -10; exp_i[2] = 1; exp_i[3] = 0; exp_i[4] = -1;
    exp_q[0] = 15; exp_q[1] = -16; exp_q[2] = 15;
    check_block("t4b", NSC, 11, 'h222, e0 + NSC);
    check("t4 sat_cnt", o_sat_cnt, 2 * sat_en);

    // Short block dropped, following block intact
    new_test(); load_t2();
    drive_block(8, 7, 9, 'h333, e0);
    drive_block(NSC, NSC - 1, 9, 'h444, e1);
    idle(22);
    check("t5 err pulses", err_cnt, 1);
    check("t5 err cycle", err_cyc, e0 + 7);
    check("t5 count", out_q.size(), NSC);
    check_block("t5", NSC, 2, 'h444, e1);

    // Reset in the middle of a block
    new_test(); load_t2();
    drive_block(5, -1, 9, 'h555, e0);
    @(negedge clk);
    rst = 1'b1; i_vld = 1'b1; i_sop = 1'b0; i_din = {16'(blk_i[5]), 16'(blk_q[5])};
    @(negedge clk);
    i_vld = 1'b0;
    check("t6 rst o_vld", o_vld, 0);
    check("t6 rst o_exp", o_exp, 0);
    check("t6 rst o_meta", o_meta, 0);
    check("t6 rst o_sat_cnt", o_sat_cnt, 0);
    rst = 1'b0;
    idle(24);
    check("t6 no output", out_q.size(), 0);
    check("t6 no err", err_cnt, 0);
    new_test();
    drive_block(NSC, NSC - 1, 9, 'h666, e1);
    idle(22);
    check("t6 count", out_q.size(), NSC);
    check_block("t6", NSC, 2, 'h666, e1);
    check("t6 sat_cnt", o_sat_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ul_bfp_compress_gen.md
Name: ul_bfp_compress_gen

Overview:
- Parametrised block-floating-point (BFP) compressor for uplink PUSCH IQ data.
- Takes fixed-size resource blocks of NSC complex samples and finds one shared exponent per block.
- Emits rounded, saturated mantissas with a mantissa width selectable at runtime. Accepts back-to-back blocks with no bubble.
- Sits between the uplink data-reduction datapath and the fronthaul packer.

Parameters:
- IW, 16, I or Q component input width (two's complement).
- MW, 9, maximum mantissa width; also the output field width per component.
- NSC, 12, samples per block.
- EW, 4, exponent width.
- META_W, 24, sideband width (slot/symbol/PRB/type), carried per block.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_vld  in  1  input sample valid
- i_sop  in  1  first sample of block (qualified by i_vld)
- i_eop  in  1  last sample of block (qualified by i_vld)
- i_din  in  2*IW  {I,Q}
- i_mw  in  4  mantissa width for this block, sampled at i_sop
- i_meta  in  META_W  sideband, sampled at i_sop
- o_vld  out  1  output valid
- o_sop  out  1  first output sample of block
- o_eop  out  1  last output sample of block
- o_dout  out  2*MW  {I,Q} mantissas, each right-aligned and sign-extended to MW
- o_exp  out  EW  block exponent
- o_meta  out  META_W  block sideband
- o_err  out  1  one-cycle pulse when a block is dropped
- o_sat_cnt  out  16  saturation counter (optional feature)

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - All outputs reset to 0.
  - FSM returns to IDLE; ping-pong bank pointers reset to bank 0.
  - Any partial or queued block is discarded with no output.
- FSM states: IDLE and COLLECT.
  - IDLE -> COLLECT on i_vld&i_sop (sample 0 written).
  - COLLECT -> IDLE on i_vld&i_eop.
- Block format: samples must arrive on consecutive cycles. Drop conditions, each giving no output and an o_err pulse:
  - i_vld low inside a block: drop, return to IDLE.
  - i_eop with count != NSC-1: drop.
  - Count reaching NSC without i_eop: drop.
  - i_sop in COLLECT: abort the current block with o_err, then start a new block at this sample.
  - i_vld without i_sop in IDLE: ignored.
- Magnitude: ones-complement magnitude per component, m = x ^ {IW{x[IW-1]}}. Running OR across I and Q of all block samples, registered.
- Exponent:
  - b = bit length of the OR result (0 if zero).
  - mw = i_mw clamped to [2, MW].
  - exp = max(0, b+1-mw), registered one cycle after the last sample.
- Quantise, per component:
  - Round half up: r = (x + (exp>0 ? 1<<(exp-1) : 0)) >>> exp, with full-precision add.
  - Saturate r to [-2^(mw-1), 2^(mw-1)-1].
  - Output sign-extended to MW bits.
- Buffering: two banks of NSC x 2*IW. Blocks alternate banks, so block N+1 is written while block N is read.
- Latency: input sample k of a block at cycle T0+k appears at T0+NSC+4+k (LAT = NSC+4).
  - o_vld is high for exactly NSC contiguous cycles.
  - o_sop is on k=0 and o_eop on k=NSC-1.
  - o_exp and o_meta are valid from o_sop and held until the next o_sop.
- Back-to-back blocks (i_sop the cycle after i_eop) produce contiguous output with no gap.
- o_err is asserted the cycle after the detecting input cycle.

Optional Feature:
- Macro: UL_BFP_SAT_CNT_EN.
- Defined: o_sat_cnt is a 16-bit counter.
  - Increments by the number of components saturated per output cycle (0, 1 or 2).
  - Sticks at 0xFFFF; cleared by rst.
- Undefined: o_sat_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package ul_bfp_pkg holds:
  - default IW/MW/NSC/EW, and MW_MIN = 2
  - state enum {IDLE, COLLECT}
  - function bitlen()
  - function clamp_mw()
- Sub-module ul_bfp_quant: one component (shift, round, saturate, sat flag), 2 register stages. Instantiated twice, for I and Q.

Test Plan (IW=16, MW=9, NSC=12):
- All-zero block, i_mw=9 -> o_exp=0, all o_dout=0, o_vld 12 cycles starting 16 cycles after i_sop.
- Max component 1000, i_mw=9 -> exp=2:
  - 1000 -> 250
  - 1003 -> 251
  - -1001 -> -250
  - 2 -> 1
- Sample 32767, i_mw=9 -> exp=7; 32767 -> 255 (saturated, o_sat_cnt +1); -32768 -> -256, not saturated.
- Two back-to-back blocks (max 100 with i_mw=9, then max 20000 with i_mw=5):
  - o_exp goes 0 then 11, switching at the second o_sop.
  - No o_vld gap; o_meta follows each block.
- Short block (i_eop on 8th sample), followed by a valid block -> single o_err pulse, no output for the first block, normal output for the second.
- rst asserted at sample 5 of a block -> no output and all outputs 0; the next block after reset is processed normally with LAT=16.
